ps2_key_event_decoder: RTL



---
 rtl/ps2_key_event_decoder_pkg.sv | 48 ++++
 rtl/ps2_key_event_decoder_if.sv | 39 +++
 rtl/ps2_key_event_decoder_fifo.sv | 64 ++++++
 rtl/ps2_key_event_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_event_decoder_pkg.sv
// ps2_kbd_pkg: shared constants, state encodings and the key event record
// for the PS/2 key event decoder.
//
// Optional build macro: KEY_REPEAT_EN. When it is defined, key_event_t gains
// an rpt bit that marks typematic repeats of a key that is already held.
package ps2_kbd_pkg;

  // Prefix bytes of the PS/2 scan code set 2 stream
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // Keyboard status/ack bytes (self-test pass, ack, resend, echo, error).
  // These never represent a key.
  localparam int N_IGNORED = 6;
  localparam logic [N_IGNORED-1:0][7:0] PS2_IGNORED =
    {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {
    DEC_FIRST,
    DEC_SEEN_E0,
    DEC_SEEN_F0,
    DEC_SEEN_E0F0
  } dec_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ACK,
    HS_WAIT_LOW
  } hs_state_t;

  typedef struct packed {
    logic       ext;
    logic       make;
    logic [7:0] code;
`ifdef KEY_REPEAT_EN
    logic       rpt;
`endif
  } key_event_t;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IGNORED; i++)
      if (b == PS2_IGNORED[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// ps2_key_event_decoder_if: byte handshake from the inner PS/2 driver plus the
// valid/ready key event stream toward game logic.
//   scan_ready/scan_code : byte offered by the inner driver
//   read                 : one-cycle acknowledge back to the inner driver
//   ev_valid/ev_ready    : event stream handshake
//   ev_code/ev_ext/ev_make (+ ev_repeat with KEY_REPEAT_EN) : event payload
// Modports: master = byte source / event sink side, slave = the decoder.
// Optional build macro: KEY_REPEAT_EN adds ev_repeat.
interface ps2_key_event_decoder_if;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       read;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_make;
`ifdef KEY_REPEAT_EN
  logic       ev_repeat;

  modport master (
    output scan_ready, scan_code, ev_ready,
    input  read, ev_valid, ev_code, ev_ext, ev_make, ev_repeat
  );
  modport slave (
    input  scan_ready, scan_code, ev_ready,
    output read, ev_valid, ev_code, ev_ext, ev_make, ev_repeat
  );
`else
  modport master (
    output scan_ready, scan_code, ev_ready,
    input  read, ev_valid, ev_code, ev_ext, ev_make
  );
  modport slave (
    input  scan_ready, scan_code, ev_ready,
    output read, ev_valid, ev_code, ev_ext, ev_make
  );
`endif
endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// ps2_event_fifo: synchronous FIFO of key_event_t records.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write request; ignored when full unless a pop happens
//                     in the same cycle
//   pop, pop_data   : pop request; pop_data shows the head entry
//   full, empty     : occupancy flags
//   drop            : push refused this cycle (full, no simultaneous pop)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Optional build macro: KEY_REPEAT_EN (widens key_event_t by one bit).
module ps2_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output key_event_t pop_data,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Cleared so the event outputs read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: turns the byte stream of a PS/2 keyboard into
// press/release events, suppressing typematic repeats for every held key.
//   CLOCK_50   : system clock
//   reset      : asynchronous, active-high
//   bus        : ps2_key_event_decoder_if.slave (byte handshake + event stream)
//   held_count : number of keys currently tracked in the held table
//   overflow   : sticky, an event was lost to a full event FIFO
// Parameters: MAX_HELD (1..16) held-table entries, FIFO_DEPTH (power of two).
// Optional build macro: KEY_REPEAT_EN -- repeats of a held key are emitted as
// make events with ev_repeat=1 instead of being swallowed.
//
// Timing: a byte seen in IDLE in cycle N is captured, decoded in cycle N+1
// (while read is high) and pushed at the end of N+1; the table and FIFO
// outputs reflect it from cycle N+2.
module ps2_key_event_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int MAX_HELD   = 4,
  parameter int FIFO_DEPTH = 8
)(
  input  logic                          CLOCK_50,
  input  logic                          reset,
  ps2_key_event_decoder_if.slave        bus,
  output logic [$clog2(MAX_HELD+1)-1:0] held_count,
  output logic                          overflow
);

  localparam int CW = $clog2(MAX_HELD+1);

  // ---------------- byte handshake ----------------
  hs_state_t  hs_q, hs_d;
  logic [7:0] byte_q;
  logic       byte_vld;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) hs_q <= HS_IDLE;
    else       hs_q <= hs_d;
  end

  always_comb begin
    hs_d = hs_q;
    case (hs_q)
      HS_IDLE:     if (bus.scan_ready) hs_d = HS_ACK;
      HS_ACK:      hs_d = HS_WAIT_LOW;
      // Holding here until scan_ready drops keeps a byte from being taken twice.
      HS_WAIT_LOW: if (!bus.scan_ready) hs_d = HS_IDLE;
      default:     hs_d = HS_IDLE;
    endcase
  end

  always_comb begin
    bus.read = (hs_q == HS_ACK);
    byte_vld = (hs_q == HS_ACK);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                              byte_q <= '0;
    else if (hs_q == HS_IDLE && bus.scan_ready) byte_q <= bus.scan_code;
  end

  // ---------------- sequence decoder ----------------
  dec_state_t dec_q, dec_d;
  logic       key_hit, key_make, key_ext;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) dec_q <= DEC_FIRST;
    else       dec_q <= dec_d;
  end

  always_comb begin
    dec_d = dec_q;
    if (byte_vld) begin
      case (dec_q)
        DEC_FIRST: begin
          if (byte_q == PS2_EXT)        dec_d = DEC_SEEN_E0;
          else if (byte_q == PS2_BREAK) dec_d = DEC_SEEN_F0;
        end
        DEC_SEEN_E0: begin
          if (byte_q == PS2_BREAK)      dec_d = DEC_SEEN_E0F0;
          else if (byte_q != PS2_EXT)   dec_d = DEC_FIRST;
        end
        default: dec_d = DEC_FIRST;
      endcase
    end
  end

  always_comb begin
    key_hit  = 1'b0;
    key_make = 1'b0;
    key_ext  = 1'b0;
    if (byte_vld) begin
      case (dec_q)
        DEC_FIRST: begin
          if (byte_q != PS2_EXT && byte_q != PS2_BREAK && !is_ignored(byte_q)) begin
            key_hit  = 1'b1;
            key_make = 1'b1;
          end
        end
        DEC_SEEN_E0: begin
          if (byte_q != PS2_EXT && byte_q != PS2_BREAK) begin
            key_hit  = 1'b1;
            key_make = 1'b1;
            key_ext  = 1'b1;
          end
        end
        DEC_SEEN_F0: key_hit = 1'b1;
        DEC_SEEN_E0F0: begin
          key_hit = 1'b1;
          key_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- held-key table ----------------
  logic [MAX_HELD-1:0]      tbl_vld;
  logic [MAX_HELD-1:0][8:0] tbl_key;
  logic [MAX_HELD-1:0]      match;
  logic [MAX_HELD-1:0]      free_oh;
  logic                     present, tbl_full;
  logic [8:0]               key_id;

  assign key_id = {key_ext, byte_q};

  for (genvar g = 0; g < MAX_HELD; g++) begin : g_match
    assign match[g] = tbl_vld[g] && (tbl_key[g] == key_id);
  end

  assign present  = |match;
  assign tbl_full = &tbl_vld;

  // Lowest free slot, one-hot
  always_comb begin
    logic found;
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < MAX_HELD; i++) begin
      if (!tbl_vld[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tbl_vld <= '0;
      tbl_key <= '0;
    end else if (key_hit) begin
      // A make with the table full is still reported, just not tracked.
      if (key_make && !present && !tbl_full) begin
        for (int i = 0; i < MAX_HELD; i++)
          if (free_oh[i]) begin
            tbl_vld[i] <= 1'b1;
            tbl_key[i] <= key_id;
          end
      end
      if (!key_make) begin
        for (int i = 0; i < MAX_HELD; i++)
          if (match[i]) tbl_vld[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    held_count = '0;
    for (int i = 0; i < MAX_HELD; i++)
      held_count = held_count + CW'(tbl_vld[i]);
  end

  // ---------------- event FIFO ----------------
  key_event_t push_ev, head_ev;
  logic       push, pop, fifo_full, fifo_empty, fifo_drop;

  always_comb begin
    push_ev      = '0;
    push_ev.ext  = key_ext;
    push_ev.make = key_make;
    push_ev.code = byte_q;
    push         = 1'b0;
    if (key_hit) begin
`ifdef KEY_REPEAT_EN
      push        = 1'b1;
      push_ev.rpt = key_make & present;
`else
      // Typematic repeat of a tracked key produces no event.
      push = !(key_make && present);
`endif
    end
  end

  assign pop = bus.ev_valid & bus.ev_ready;

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (push),
    .push_data (push_ev),
    .pop       (pop),
    .pop_data  (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign bus.ev_valid = ~fifo_empty;
  assign bus.ev_code  = head_ev.code;
  assign bus.ev_ext   = head_ev.ext;
  assign bus.ev_make  = head_ev.make;
`ifdef KEY_REPEAT_EN
  assign bus.ev_repeat = head_ev.rpt;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

endmodule
